spec_add_recovery: RTL and testbench

SPEC_ADD_RECOVERY -- requirements
Module: spec_add_recovery

---
 rtl/spec_add_pkg.sv | 33 +++
 rtl/spec_block_pg.sv | 48 ++++
 rtl/spec_add_recovery.sv | 164 ++++++++++++++++
 tb/tb_spec_add_recovery.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spec_add_pkg.sv
// Shared definitions for the speculative adder with error recovery.
// Holds default widths, FSM state encoding, the G/P pair type and the
// gray/black prefix-cell primitives used by the block and carry chains.
package spec_add_pkg;

  localparam int unsigned DEF_WIDTH = 16;
  localparam int unsigned DEF_BLOCK = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SPEC = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  // Gray cell: combined generate of a high span over a low span.
  function automatic logic gray_cell(input logic g_hi, input logic p_hi, input logic g_lo);
    return g_hi | (p_hi & g_lo);
  endfunction

  // Black cell: combined generate and propagate of two adjacent spans.
  function automatic gp_t black_cell(input gp_t hi, input gp_t lo);
    gp_t r;
    r.g = gray_cell(hi.g, hi.p, lo.g);
    r.p = hi.p & lo.p;
    return r;
  endfunction

endpackage

// File: rtl/spec_block_pg.sv
// Per-block generate/propagate prefix for one speculation block.
// Ports:
//   i_a, i_b  - block slices of the addends
//   o_p_bit   - bitwise propagate (a ^ b), used for the sum bits
//   o_pre_g   - prefix generate over bits [i:0] of the block
//   o_pre_p   - prefix propagate over bits [i:0] of the block
//   o_grp_g   - group generate of the whole block
//   o_grp_p   - group propagate of the whole block
module spec_block_pg
  import spec_add_pkg::*;
#(
  parameter int unsigned BLOCK = DEF_BLOCK
) (
  input  logic [BLOCK-1:0] i_a,
  input  logic [BLOCK-1:0] i_b,
  output logic [BLOCK-1:0] o_p_bit,
  output logic [BLOCK-1:0] o_pre_g,
  output logic [BLOCK-1:0] o_pre_p,
  output logic             o_grp_g,
  output logic             o_grp_p
);

  logic [BLOCK-1:0] w_g;
  logic [BLOCK-1:0] w_p;

  assign w_g     = i_a & i_b;
  assign w_p     = i_a ^ i_b;
  assign o_p_bit = w_p;

  // Serial prefix of black cells from bit 0 upward.
  always_comb begin
    gp_t w_acc;
    o_pre_g = '0;
    o_pre_p = '0;
    w_acc   = gp_t'{g: w_g[0], p: w_p[0]};
    o_pre_g[0] = w_acc.g;
    o_pre_p[0] = w_acc.p;
    for (int i = 1; i < BLOCK; i++) begin
      w_acc      = black_cell(gp_t'{g: w_g[i], p: w_p[i]}, w_acc);
      o_pre_g[i] = w_acc.g;
      o_pre_p[i] = w_acc.p;
    end
  end

  assign o_grp_g = o_pre_g[BLOCK-1];
  assign o_grp_p = o_pre_p[BLOCK-1];

endmodule

// File: rtl/spec_add_recovery.sv
// Speculative block-carry adder with one-cycle error recovery.
// Carry into each block is guessed from the previous block's group
// generate; if any guess is wrong the exact result is registered and
// presented one cycle later with 'corrected' set.
// Ports:
//   clk, rst             - clock, synchronous active-high reset
//   in_valid / in_ready  - operand handshake (a, b, cin)
//   out_valid / out_ready- result handshake (sum, cout, corrected)
// WIDTH must be a multiple of BLOCK.
module spec_add_recovery
  import spec_add_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned BLOCK = DEF_BLOCK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             corrected
);

  localparam int unsigned NBLK = WIDTH / BLOCK;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_cin;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;

  logic [WIDTH-1:0] w_p_bit;
  logic [WIDTH-1:0] w_pre_g;
  logic [WIDTH-1:0] w_pre_p;
  logic [NBLK-1:0]  w_grp_g;
  logic [NBLK-1:0]  w_grp_p;
  logic [NBLK:0]    w_cx;
  logic [NBLK:0]    w_cs;
  logic [WIDTH-1:0] w_sum_x;
  logic [WIDTH-1:0] w_sum_s;
  logic             w_err;
  logic             w_accept;
  logic             w_load_fix;

  for (genvar k = 0; k < NBLK; k++) begin : g_blk
    spec_block_pg #(.BLOCK(BLOCK)) u_pg (
      .i_a     (r_a[k*BLOCK +: BLOCK]),
      .i_b     (r_b[k*BLOCK +: BLOCK]),
      .o_p_bit (w_p_bit[k*BLOCK +: BLOCK]),
      .o_pre_g (w_pre_g[k*BLOCK +: BLOCK]),
      .o_pre_p (w_pre_p[k*BLOCK +: BLOCK]),
      .o_grp_g (w_grp_g[k]),
      .o_grp_p (w_grp_p[k])
    );
  end

  // Block carries: exact chain (w_cx), speculative guesses (w_cs), error flag.
  // A guess is wrong only when the previous block propagates a true carry.
  always_comb begin
    w_cx    = '0;
    w_cs    = '0;
    w_err   = 1'b0;
    w_cx[0] = r_cin;
    w_cs[0] = r_cin;
    for (int k = 0; k < NBLK; k++) begin
      w_cx[k+1] = gray_cell(w_pre_g[k*BLOCK+BLOCK-1], w_pre_p[k*BLOCK+BLOCK-1], w_cx[k]);
    end
    for (int k = 1; k < NBLK; k++) begin
      w_cs[k] = w_grp_g[k-1];
      w_err   = w_err | (w_grp_p[k-1] & w_cx[k-1]);
    end
    w_cs[NBLK] = gray_cell(w_grp_g[NBLK-1], w_grp_p[NBLK-1], w_cs[NBLK-1]);
  end

  // Sum bits from block carry-in plus in-block prefix, for both carry sets.
  always_comb begin
    w_sum_x = '0;
    w_sum_s = '0;
    for (int k = 0; k < NBLK; k++) begin
      w_sum_x[k*BLOCK] = w_p_bit[k*BLOCK] ^ w_cx[k];
      w_sum_s[k*BLOCK] = w_p_bit[k*BLOCK] ^ w_cs[k];
      for (int i = 1; i < BLOCK; i++) begin
        w_sum_x[k*BLOCK+i] = w_p_bit[k*BLOCK+i]
          ^ gray_cell(w_pre_g[k*BLOCK+i-1], w_pre_p[k*BLOCK+i-1], w_cx[k]);
        w_sum_s[k*BLOCK+i] = w_p_bit[k*BLOCK+i]
          ^ gray_cell(w_pre_g[k*BLOCK+i-1], w_pre_p[k*BLOCK+i-1], w_cs[k]);
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state, handshake and result selection.
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    corrected   = 1'b0;
    w_load_fix  = 1'b0;
    sum         = r_sum;
    cout        = r_cout;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = ST_SPEC;
      end
      ST_SPEC: begin
        if (w_err) begin
          w_load_fix  = 1'b1;
          w_state_nxt = ST_FIX;
        end else begin
          out_valid = 1'b1;
          in_ready  = out_ready;
          sum       = w_sum_s;
          cout      = w_cs[NBLK];
          if (out_ready) w_state_nxt = in_valid ? ST_SPEC : ST_IDLE;
        end
      end
      ST_FIX: begin
        out_valid = 1'b1;
        corrected = 1'b1;
        in_ready  = out_ready;
        if (out_ready) w_state_nxt = in_valid ? ST_SPEC : ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_accept = in_valid & in_ready;

  // Operand capture and recovered-result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_cin  <= 1'b0;
      r_sum  <= '0;
      r_cout <= 1'b0;
    end else begin
      if (w_accept) begin
        r_a   <= a;
        r_b   <= b;
        r_cin <= cin;
      end
      if (w_load_fix) begin
        r_sum  <= w_sum_x;
        r_cout <= w_cx[NBLK];
      end
    end
  end

endmodule

// File: tb/tb_spec_add_recovery.sv
module tb_spec_add_recovery;

  localparam int unsigned W  = 16;
  localparam int unsigned B  = 4;
  localparam int unsigned NB = W / B;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         corr;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         corrected;

  int   n_checks;
  int   n_fail;
  exp_t q[$];

  spec_add_recovery #(.WIDTH(W), .BLOCK(B)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .corrected (corrected)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: arithmetic sum plus block-level misprediction detection.
  function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mc);
    logic [W:0]   full;
    logic [W:0]   mask;
    logic [W:0]   part;
    logic [W-1:0] px;
    logic         err;
    exp_t         e;
    full = {1'b0, ma} + {1'b0, mb} + (W+1)'(mc);
    px   = ma ^ mb;
    err  = 1'b0;
    for (int k = 1; k < NB; k++) begin
      int unsigned lo;
      lo   = (k - 1) * B;
      mask = ((W+1)'(1) << lo) - (W+1)'(1);
      part = ({1'b0, ma} & mask) + ({1'b0, mb} & mask) + (W+1)'(mc);
      if ((&px[lo +: B]) && part[lo]) err = 1'b1;
    end
    e.sum  = full[W-1:0];
    e.cout = full[W];
    e.corr = err;
    return e;
  endfunction

  task automatic cyc(input logic r, input logic v, input logic [W-1:0] ai,
                     input logic [W-1:0] bi, input logic ci, input logic ordy);
    @(negedge clk);
    rst       = r;
    in_valid  = v;
    a         = ai;
    b         = bi;
    cin       = ci;
    out_ready = ordy;
    #1;
  endtask

  task automatic test_reset();
    cyc(1'b1, 1'b1, 16'h00FF, 16'h0001, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 16'h00FF, 16'h0001, 1'b0, 1'b1);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_checks++; if (sum !== 16'h0000) begin n_fail++; $display("FAIL reset_sum got %h want 0000", sum); end
    n_checks++; if (cout !== 1'b0) begin n_fail++; $display("FAIL reset_cout got %b want 0", cout); end
    n_checks++; if (corrected !== 1'b0) begin n_fail++; $display("FAIL reset_corrected got %b want 0", corrected); end
    cyc(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_idle_valid got %b want 0", out_valid); end
  endtask

  task automatic test_basic();
    cyc(1'b0, 1'b1, 16'h0001, 16'h0001, 1'b0, 1'b1);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_in_ready got %b want 1", in_ready); end
    cyc(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_latency got out_valid=%b want 1", out_valid); end
    n_checks++; if ({sum, cout, corrected} !== {16'h0002, 1'b0, 1'b0})
      begin n_fail++; $display("FAIL basic_result got %h/%b/%b want 0002/0/0", sum, cout, corrected); end
    cyc(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_return_idle got %b want 0", out_valid); end
  endtask

  task automatic test_recover();
    // 0x00FF + 1: carry ripples through a propagating block
    cyc(1'b0, 1'b1, 16'h00FF, 16'h0001, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL recov_t1_valid got %b want 0", out_valid); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL recov_t1_ready got %b want 0", in_ready); end
    cyc(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL recov_t2_valid got %b want 1", out_valid); end
    n_checks++; if ({sum, cout, corrected} !== {16'h0100, 1'b0, 1'b1})
      begin n_fail++; $display("FAIL recov_00ff got %h/%b/%b want 0100/0/1", sum, cout, corrected); end
    // 0xFFFF + 1: wrap with carry-out
    cyc(1'b0, 1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b1);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL recov_fix_ready got %b want 1", in_ready); end
    cyc(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL recov_ffff_t1 got %b want 0", out_valid); end
    cyc(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
    n_checks++; if ({out_valid, sum, cout, corrected} !== {1'b1, 16'h0000, 1'b1, 1'b1})
      begin n_fail++; $display("FAIL recov_ffff got v=%b %h/%b/%b want 1 0000/1/1", out_valid, sum, cout, corrected); end
    cyc(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL recov_idle got %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] ta, tb;
    logic         tc;
    exp_t         e;
    int           outs;
    outs = 0;
    for (int i = 0; i < 12; i++) begin
      ta = '0; tb = '0; tc = 1'b0;
      if (i < 10) begin
        do begin
          ta = 16'($urandom());
          tb = 16'($urandom());
          tc = 1'($urandom_range(0, 1));
          e  = model(ta, tb, tc);
        end while (e.corr);
      end
      cyc(1'b0, 1'(i < 10), ta, tb, tc, 1'b1);
      if (i < 10) begin
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready cyc %0d got %b want 1", i, in_ready); end
      end
      n_checks++; if (out_valid !== 1'(i >= 1 && i <= 10))
        begin n_fail++; $display("FAIL b2b_out_valid cyc %0d got %b want %b", i, out_valid, (i >= 1 && i <= 10)); end
      if (out_valid && out_ready) begin
        outs++;
        n_checks++;
        if (q.size() == 0) begin n_fail++; $display("FAIL b2b_unexpected got %h want none", sum); end
        else begin
          e = q.pop_front();
          if ({sum, cout, corrected} !== e) begin
            n_fail++; $display("FAIL b2b_result got %h/%b/%b want %h/%b/%b", sum, cout, corrected, e.sum, e.cout, e.corr);
          end
        end
      end
      if (in_valid && in_ready) q.push_back(model(a, b, cin));
    end
    n_checks++; if (outs != 10 || q.size() != 0)
      begin n_fail++; $display("FAIL b2b_count got %0d left %0d want 10 left 0", outs, q.size()); end
  endtask

  task automatic test_backpressure();
    cyc(1'b0, 1'b1, 16'h1234, 16'h0101, 1'b0, 1'b1);
    for (int j = 0; j < 3; j++) begin
      cyc(1'b0, 1'b1, 16'hAAAA, 16'h1111, 1'b1, 1'b0);
      n_checks++; if ({out_valid, in_ready} !== 2'b10)
        begin n_fail++; $display("FAIL bp_handshake cyc %0d got v=%b r=%b want v=1 r=0", j, out_valid, in_ready); end
      n_checks++; if ({sum, cout, corrected} !== {16'h1335, 1'b0, 1'b0})
        begin n_fail++; $display("FAIL bp_stable cyc %0d got %h/%b/%b want 1335/0/0", j, sum, cout, corrected); end
    end
    cyc(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
    n_checks++; if ({out_valid, sum} !== {1'b1, 16'h1335})
      begin n_fail++; $display("FAIL bp_release got v=%b %h want 1 1335", out_valid, sum); end
    cyc(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_no_accept got %b want 0", out_valid); end
  endtask

  task automatic test_reset_midflight();
    cyc(1'b0, 1'b1, 16'h00FF, 16'h0001, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 16'h0003, 16'h0004, 1'b0, 1'b1);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_err_cycle got %b want 0", out_valid); end
    cyc(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
    n_checks++; if ({out_valid, in_ready, sum, cout, corrected} !== {1'b0, 1'b1, 16'h0000, 1'b0, 1'b0})
      begin n_fail++; $display("FAIL mid_reset got v=%b r=%b %h/%b/%b want 0 1 0000/0/0", out_valid, in_ready, sum, cout, corrected); end
    for (int j = 0; j < 3; j++) begin
      cyc(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_stale cyc %0d got %b want 0", j, out_valid); end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] ta, tb, hs;
    logic         tc, v, r, held, hc, hk;
    exp_t         e;
    held = 1'b0; hs = '0; hc = 1'b0; hk = 1'b0;
    for (int i = 0; i < 420; i++) begin
      v  = (i < 400) && ($urandom_range(0, 9) < 7);
      r  = (i >= 400) || ($urandom_range(0, 9) < 7);
      ta = 16'($urandom());
      tc = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 2))
        0:       tb = 16'($urandom());
        1:       tb = ~ta ^ 16'($urandom_range(0, 3));
        default: tb = 16'($urandom_range(0, 3));
      endcase
      cyc(1'b0, v, ta, tb, tc, r);
      if (held) begin
        n_checks++;
        if ({out_valid, sum, cout, corrected} !== {1'b1, hs, hc, hk}) begin
          n_fail++; $display("FAIL rnd_hold cyc %0d got v=%b %h/%b/%b want 1 %h/%b/%b", i, out_valid, sum, cout, corrected, hs, hc, hk);
        end
      end
      if (out_valid && out_ready) begin
        n_checks++;
        if (q.size() == 0) begin n_fail++; $display("FAIL rnd_unexpected cyc %0d got %h want none", i, sum); end
        else begin
          e = q.pop_front();
          if ({sum, cout, corrected} !== e) begin
            n_fail++; $display("FAIL rnd_result cyc %0d got %h/%b/%b want %h/%b/%b", i, sum, cout, corrected, e.sum, e.cout, e.corr);
          end
        end
      end
      if (in_valid && in_ready) q.push_back(model(a, b, cin));
      held = out_valid && !out_ready;
      hs = sum; hc = cout; hk = corrected;
    end
    n_checks++; if (q.size() != 0) begin n_fail++; $display("FAIL rnd_drain got %0d pending want 0", q.size()); end
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_basic();
    test_recover();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
